// File: rtl/dmem_responder.sv
// Data-memory responder: zero-wait-state loads, stores posted into an
// in-order store buffer that drains into a single-port word RAM whenever
// the RAM port is otherwise idle. Loads forward from the youngest
// matching buffered store.
module dmem_responder #(
   parameter int N     = 64,
   parameter int DEPTH = 4,
   parameter int AW    = 6
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N-1:0]               DM_addr,
   input  logic [N-1:0]               DM_writeData,
   input  logic                       DM_writeEnable,
   input  logic                       DM_readEnable,
   output logic [N-1:0]               DM_readData,
   output logic [$clog2(DEPTH):0]     sb_count,
   output logic                       sb_empty,
   output logic                       sb_full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Word RAM (contents deliberately not reset) and store-buffer entries
   logic [N-1:0]    ram     [2**AW];
   logic [AW-1:0]   sb_idx  [DEPTH];
   logic [N-1:0]    sb_data [DEPTH];
   logic [DEPTH-1:0] valid_reg;

   logic [PW-1:0]   head_reg, head_next;
   logic [PW-1:0]   tail_reg, tail_next;
   logic [CW-1:0]   count_reg, count_next;

   logic [AW-1:0]   req_idx;
   logic            read_req;
   logic            write_req;
   logic            full;
   logic            empty;
   logic            drain;
   logic            hit;
   logic [N-1:0]    fwd_data;
   logic            unused_bits;

   // Byte offset and address bits above the RAM range are ignored (aliasing)
   assign req_idx     = DM_addr[AW+2:3];
   assign unused_bits = ^{DM_addr[N-1:AW+3], DM_addr[2:0]};

   // A cycle with both enables is a read; the write is dropped
   assign read_req  = DM_readEnable;
   assign write_req = DM_writeEnable & ~DM_readEnable;
   assign full      = (count_reg == CW'(DEPTH));
   assign empty     = (count_reg == '0);

   // The RAM port drains on idle cycles, or when a store arrives at a full buffer
   assign drain = (~read_req & ~write_req & ~empty) | (write_req & full);

   // Next pointer/count values
   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (write_req)
         tail_next = tail_reg + 1'b1;
      if (drain)
         head_next = head_reg + 1'b1;
      if (write_req && !full)
         count_next = count_reg + 1'b1;
      else if (drain && !write_req)
         count_next = count_reg - 1'b1;
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   // Per-entry valid bit; an enqueue wins over a drain of the same slot (full case)
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               valid_reg[gi] <= 1'b0;
            else if (write_req && tail_reg == PW'(gi))
               valid_reg[gi] <= 1'b1;
            else if (drain && head_reg == PW'(gi))
               valid_reg[gi] <= 1'b0;
         end
      end
   endgenerate

   // Entry payload capture at the tail
   always_ff @(posedge clk) begin
      if (write_req) begin
         sb_idx[tail_reg]  <= req_idx;
         sb_data[tail_reg] <= DM_writeData;
      end
   end

   // Oldest entry drains into RAM
   always_ff @(posedge clk) begin
      if (drain)
         ram[sb_idx[head_reg]] <= sb_data[head_reg];
   end

   // Forwarding search in age order, oldest first, so the youngest match wins
   always_comb begin
      logic [PW-1:0] pos;
      hit      = 1'b0;
      fwd_data = '0;
      pos      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         pos = head_reg + PW'(k);
         if (valid_reg[pos] && sb_idx[pos] == req_idx) begin
            hit      = 1'b1;
            fwd_data = sb_data[pos];
         end
      end
   end

   // Same-cycle load data; zero when not reading or while in reset
   always_comb begin
      DM_readData = '0;
      if (!reset && read_req)
         DM_readData = hit ? fwd_data : ram[req_idx];
   end

   assign sb_count = count_reg;
   assign sb_empty = empty;
   assign sb_full  = full;

endmodule
